// File: rtl/ifetch_ctrl.sv
// Fetch controller: owns the fetch address and drives a variable-latency req/gnt/rvalid
// instruction port into a one-entry output slot. Optional stall counter via IFC_PERF_CNT_EN.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pipe_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pcnext_out,
  output logic        fetch_stall,
  output logic        fetch_err,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {REQ, WAIT, ERR} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] fa_q, fa_d;
  logic        valid_q, valid_d;
  logic        kill_q, kill_d;
  logic [15:0] cnt_q, cnt_d;
  logic        load;
  logic [31:0] instr_q, pc_q, pcnext_q;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    valid_d = valid_q;
    kill_d  = kill_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    mem_req = 1'b0;

    if (valid_q && !pipe_stall) valid_d = 1'b0;

    case (state_q)
      REQ: begin
        // Hold off only when the slot is full and will not drain this cycle.
        mem_req = rstn && !(valid_q && pipe_stall);
        if (mem_req && mem_gnt) begin
          state_d = WAIT;
          cnt_d   = '0;
          kill_d  = redirect;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redirect) begin
            load    = 1'b1;
            valid_d = 1'b1;
            fa_d    = fa_q + 32'd4;
          end
        end else begin
          if (redirect) kill_d = 1'b1;
          if (cnt_q == TO_LAST) state_d = ERR;
          else                  cnt_d   = cnt_q + 16'd1;
        end
      end
      ERR: valid_d = 1'b0;
      default: state_d = REQ;
    endcase

    // A redirect always wins: retarget and flush the slot, stalled or not.
    if (redirect) begin
      fa_d    = align_word(redirect_pc);
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= REQ;
      fa_q     <= RESET_PC;
      valid_q  <= 1'b0;
      kill_q   <= 1'b0;
      cnt_q    <= '0;
      pc_q     <= '0;
      pcnext_q <= '0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      if (load) begin
        pc_q     <= fa_q;
        pcnext_q <= fa_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) instr_q <= mem_rdata;
  end

  assign mem_addr    = fa_q;
  assign instr_valid = valid_q;
  assign instr_out   = valid_q ? instr_q : NOP_INSTR;
  assign pc_out      = pc_q;
  assign pcnext_out  = pcnext_q;
  assign fetch_stall = !valid_q;
  assign fetch_err   = (state_q == ERR);

`ifdef IFC_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            perf_q <= '0;
    else if (!valid_q && state_q != ERR)  perf_q <= sat_inc32(perf_q);
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: a behavioural memory answers requests, deliveries are
// checked against a queue of expected (pc, instr) pairs, handshake addresses against a list.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rstn;
  logic        pipe_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pcnext_out;
  logic        fetch_stall;
  logic        fetch_err;
  logic [31:0] perf_stall_cnt;

  ifetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (8),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .pipe_stall    (pipe_stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .pcnext_out    (pcnext_out),
    .fetch_stall   (fetch_stall),
    .fetch_err     (fetch_err),
    .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hs_q[$];
  int          errors = 0;
  int          checks = 0;

  logic        gnt_en, rv_hold;
  int          rv_lat;
  logic        pend;
  logic [31:0] paddr;
  int          age;

  assign mem_gnt = gnt_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = 32'hAAAA_0000 + pc;
    exp_q.push_back(e);
  endfunction

  // Memory: grant when gnt_en, answer rv_lat cycles after the handshake unless held.
  initial begin
    logic        fire, rv;
    logic [31:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    pend       = 1'b0;
    paddr      = '0;
    age        = 0;
    forever begin
      @(negedge clk);
      if (!rstn) pend = 1'b0;
      else if (pend) age++;
      mem_rvalid = pend && !rv_hold && (age >= rv_lat);
      mem_rdata  = 32'hAAAA_0000 + paddr;
      #4;
      fire = rstn && mem_req && mem_gnt;
      rv   = mem_rvalid;
      a    = mem_addr;
      @(posedge clk);
      if (rv) pend = 1'b0;
      if (fire) begin
        pend  = 1'b1;
        paddr = a;
        age   = 0;
        hs_q.push_back(a);
      end
    end
  end

  // Monitor: every new slot fill is one delivery, compared against the queue head.
  initial begin
    logic mon_prev;
    exp_t e;
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) mon_prev = 1'b0;
      else begin
        if (instr_valid && !mon_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got pc %h instr %h, expected none", pc_out, instr_out);
          end else begin
            e = exp_q.pop_front();
            chk("deliv_instr", instr_out, e.instr);
            chk("deliv_pc", pc_out, e.pc);
            chk("deliv_pcnext", pcnext_out, e.pc + 32'd4);
            chk("deliv_fetch_stall", {31'b0, fetch_stall}, 32'd0);
          end
        end
        mon_prev = instr_valid;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_slot(input logic [31:0] pc, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (instr_valid && pc_out == pc) found = 1'b1;
    end
    chk($sformatf("wait_slot_%h", pc), {31'b0, found}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        found, fe;
    int          k;
    logic [31:0] hs_exp[10];
    logic [31:0] hs_val;
    hs_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h200, 32'h300, 32'h304, 32'h0};

    rstn        = 1'b0;
    pipe_stall  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    gnt_en      = 1'b1;
    rv_lat      = 1;
    rv_hold     = 1'b0;

    repeat (3) step();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_instr_out", instr_out, 32'h0000_0013);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_pcnext_out", pcnext_out, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Sequential fetch 0,4,8 with single-cycle memory.
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    rstn = 1'b1;
    wait_slot(32'h8, 20);

    // Hold the slot for five cycles.
    pipe_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_mem_req", {31'b0, mem_req}, 32'd0);
      chk("stall_instr_out", instr_out, 32'hAAAA_0008);
      chk("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
    end
    pipe_stall = 1'b0;
    rv_lat     = 3;
    push_exp(32'hC);

    // Redirect to 0x100 while waiting for 0x10.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (pend && paddr == 32'h10 && !mem_rvalid) found = 1'b1;
    end
    chk("wait_hs_10", {31'b0, found}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    push_exp(32'h100);
    step();
    redirect = 1'b0;
    wait_slot(32'h100, 20);

    // Redirect flushes a full, stalled slot.
    pipe_stall  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    chk("flush_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("flush_instr_out", instr_out, 32'h0000_0013);
    chk("flush_mem_req", {31'b0, mem_req}, 32'd1);
    chk("flush_mem_addr", mem_addr, 32'h200);

    // Redirect in the same cycle as rvalid for 0x200, stall still held.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mem_rvalid && paddr == 32'h200) found = 1'b1;
    end
    chk("wait_rv_200", {31'b0, found}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    chk("rvredir_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rvredir_instr_out", instr_out, 32'h0000_0013);
    chk("rvredir_mem_addr", mem_addr, 32'h300);
    chk("rvredir_mem_req", {31'b0, mem_req}, 32'd1);
    push_exp(32'h300);
    wait_slot(32'h300, 20);

    // Timeout: 0x304 granted but never answered.
    rv_hold    = 1'b1;
    pipe_stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (pend && paddr == 32'h304) found = 1'b1;
    end
    chk("wait_hs_304", {31'b0, found}, 32'd1);
    chk("pre_timeout_err", {31'b0, fetch_err}, 32'd0);
    k  = 0;
    fe = 1'b0;
    for (int i = 0; i < 20 && !fe; i++) begin
      step();
      k++;
      if (fetch_err) fe = 1'b1;
    end
    chk("timeout_cycles", k, 32'd8);
    rv_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_sticky", {31'b0, fetch_err}, 32'd1);
      chk("err_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("err_mem_req", {31'b0, mem_req}, 32'd0);
    end

    // Reset clears the error; no grant for ten cycles afterwards.
    step();
    rstn   = 1'b0;
    gnt_en = 1'b0;
    #1;
    chk("rst2_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst2_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst2_pc_out", pc_out, 32'd0);
    chk("rst2_instr_out", instr_out, 32'h0000_0013);
    chk("rst2_perf", perf_stall_cnt, 32'd0);
    repeat (2) step();
    rstn = 1'b1;
    repeat (10) step();
`ifdef IFC_PERF_CNT_EN
    chk("perf_stall_cnt", perf_stall_cnt, 32'd10);
`else
    chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
    chk("refetch_mem_req", {31'b0, mem_req}, 32'd1);
    chk("refetch_mem_addr", mem_addr, 32'h0);
    rv_lat = 1;
    gnt_en = 1'b1;
    push_exp(32'h0);
    wait_slot(32'h0, 20);
    pipe_stall = 1'b1;
    gnt_en     = 1'b0;
    repeat (3) step();

    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("hs_count", hs_q.size(), 32'd10);
    for (int i = 0; i < 10 && i < hs_q.size(); i++) begin
      hs_val = hs_q[i];
      chk($sformatf("hs_addr_%0d", i), hs_val, hs_exp[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
